// File: rtl/serial_msg_pkg.sv
// Package for the serial message framer.
// Holds the header byte tables, the header length, the framer state type,
// the idle timeout length and the header match-step helper.
// The optional idle timeout is enabled by defining SERIAL_MSG_TIMEOUT_EN.
package serial_msg_pkg;

  localparam int unsigned HEADER_LENGHT  = 5;
  localparam int unsigned TIMEOUT_CYCLES = 1024;
  localparam int unsigned IDX_W          = $clog2(HEADER_LENGHT + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [HEADER_LENGHT-1:0][7:0] hdr_t;

  // Element 0 is the first byte on the wire.
  localparam hdr_t PARTICLE_HDR = {8'd74, 8'd73, 8'd72, 8'd71, 8'd70}; // "FGHIJ"
  localparam hdr_t MAP_HDR      = {8'd74, 8'd73, 8'd80, 8'd65, 8'd77}; // "MAPIJ"

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD_PARTICLE,
    PAYLOAD_MAP
  } state_t;

  // Advance a header match index by one received byte. A mismatch can still
  // be the start of a fresh header, so it restarts at 1 rather than 0.
  function automatic idx_t next_match_idx(input idx_t idx, input logic [7:0] b,
                                          input hdr_t hdr);
    if (b == hdr[idx])
      return idx + idx_t'(1);
    else if (b == hdr[0])
      return idx_t'(1);
    else
      return '0;
  endfunction

endpackage

// File: rtl/serial_msg_rx_byte_strobe.sv
// serial_byte_strobe: turns the UART byte-ready level into a single-cycle
// accept pulse on its rising edge and forwards the byte alongside it.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   i_ready    in   UART byte-valid level
//   i_data     in   UART byte, stable while i_ready is high
//   o_accept   out  1-cycle pulse, first cycle i_ready is seen high
//   o_byte     out  byte to capture in the accept cycle
module serial_byte_strobe (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ready,
  input  logic [7:0] i_data,
  output logic       o_accept,
  output logic [7:0] o_byte
);

  logic r_prev_ready;

  always_ff @(posedge clk) begin
    if (reset)
      r_prev_ready <= 1'b0;
    else
      r_prev_ready <= i_ready;
  end

  assign o_accept = i_ready & ~r_prev_ready;
  assign o_byte   = i_data;

endmodule

// File: rtl/serial_msg_rx.sv
// serial_msg_rx: frames raw UART bytes into particle or map messages.
// Hunts for a 5-byte header, then streams the payload bytes on msg_out with
// a 1-cycle type strobe, one cycle after each byte is accepted.
// Optional macro SERIAL_MSG_TIMEOUT_EN: abandon a partial payload after
// TIMEOUT_CYCLES idle cycles and return to header hunting.
// Ports:
//   clk                 in   system clock
//   reset               in   synchronous active-high reset
//   rx_data_ready       in   UART byte-valid level
//   rx_data             in   UART byte
//   msg_out             out  current payload byte (holds between strobes)
//   particle_data_flag  out  1-cycle strobe, msg_out is particle payload
//   map_data_flag       out  1-cycle strobe, msg_out is map payload
module serial_msg_rx #(
  parameter int unsigned HEADER_LENGHT       = serial_msg_pkg::HEADER_LENGHT,
  parameter int unsigned DATA_MESSAGE_LENGHT = 16,
  parameter int unsigned MAP_DATA_LENGHT     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_data_ready,
  input  logic [7:0] rx_data,
  output logic [7:0] msg_out,
  output logic       particle_data_flag,
  output logic       map_data_flag
);

  import serial_msg_pkg::*;

  localparam int unsigned PARTICLE_MESSAGE_LENGHT = HEADER_LENGHT + DATA_MESSAGE_LENGHT;
  localparam int unsigned MAP_MESSAGE_LENGHT      = HEADER_LENGHT + MAP_DATA_LENGHT;
  localparam int unsigned MAX_PAYLOAD = (DATA_MESSAGE_LENGHT > MAP_DATA_LENGHT) ?
                                        DATA_MESSAGE_LENGHT : MAP_DATA_LENGHT;
  localparam int unsigned CNT_W = $clog2(MAX_PAYLOAD) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t P_LAST = cnt_t'(PARTICLE_MESSAGE_LENGHT - HEADER_LENGHT - 1);
  localparam cnt_t M_LAST = cnt_t'(MAP_MESSAGE_LENGHT - HEADER_LENGHT - 1);
  localparam idx_t HDR_DONE = idx_t'(HEADER_LENGHT);

  logic       w_accept;
  logic [7:0] w_byte;

  state_t     r_state,  w_state_nxt;
  idx_t       r_p_idx,  w_p_idx_nxt, w_p_step;
  idx_t       r_m_idx,  w_m_idx_nxt, w_m_step;
  cnt_t       r_cnt,    w_cnt_nxt;
  logic [7:0] r_msg,    w_msg_nxt;
  logic       r_pflag,  w_pflag_nxt;
  logic       r_mflag,  w_mflag_nxt;

`ifdef SERIAL_MSG_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
  logic [IDLE_W-1:0] r_idle, w_idle_nxt;
`endif

  serial_byte_strobe u_strobe (
    .clk      (clk),
    .reset    (reset),
    .i_ready  (rx_data_ready),
    .i_data   (rx_data),
    .o_accept (w_accept),
    .o_byte   (w_byte)
  );

  assign w_p_step = next_match_idx(r_p_idx, w_byte, PARTICLE_HDR);
  assign w_m_step = next_match_idx(r_m_idx, w_byte, MAP_HDR);

  always_comb begin
    w_state_nxt = r_state;
    w_p_idx_nxt = r_p_idx;
    w_m_idx_nxt = r_m_idx;
    w_cnt_nxt   = r_cnt;
    w_msg_nxt   = r_msg;
    w_pflag_nxt = 1'b0;
    w_mflag_nxt = 1'b0;
`ifdef SERIAL_MSG_TIMEOUT_EN
    w_idle_nxt  = '0;
`endif

    case (r_state)
      HUNT: begin
        if (w_accept) begin
          w_p_idx_nxt = w_p_step;
          w_m_idx_nxt = w_m_step;
          // Particle is checked first so it wins a simultaneous completion.
          if (w_p_step == HDR_DONE) begin
            w_state_nxt = PAYLOAD_PARTICLE;
            w_cnt_nxt   = '0;
            w_p_idx_nxt = '0;
            w_m_idx_nxt = '0;
          end else if (w_m_step == HDR_DONE) begin
            w_state_nxt = PAYLOAD_MAP;
            w_cnt_nxt   = '0;
            w_p_idx_nxt = '0;
            w_m_idx_nxt = '0;
          end
        end
      end
      PAYLOAD_PARTICLE, PAYLOAD_MAP: begin
        if (w_accept) begin
          w_msg_nxt   = w_byte;
          w_pflag_nxt = (r_state == PAYLOAD_PARTICLE);
          w_mflag_nxt = (r_state == PAYLOAD_MAP);
          if (r_cnt == ((r_state == PAYLOAD_PARTICLE) ? P_LAST : M_LAST)) begin
            w_state_nxt = HUNT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + cnt_t'(1);
          end
        end
`ifdef SERIAL_MSG_TIMEOUT_EN
        else if (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = HUNT;
          w_cnt_nxt   = '0;
        end else begin
          w_idle_nxt  = r_idle + IDLE_W'(1);
        end
`endif
      end
      default: begin
        w_state_nxt = HUNT;
        w_cnt_nxt   = '0;
        w_p_idx_nxt = '0;
        w_m_idx_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HUNT;
      r_p_idx <= '0;
      r_m_idx <= '0;
      r_cnt   <= '0;
      r_msg   <= '0;
      r_pflag <= 1'b0;
      r_mflag <= 1'b0;
`ifdef SERIAL_MSG_TIMEOUT_EN
      r_idle  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_p_idx <= w_p_idx_nxt;
      r_m_idx <= w_m_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_msg   <= w_msg_nxt;
      r_pflag <= w_pflag_nxt;
      r_mflag <= w_mflag_nxt;
`ifdef SERIAL_MSG_TIMEOUT_EN
      r_idle  <= w_idle_nxt;
`endif
    end
  end

  assign msg_out            = r_msg;
  assign particle_data_flag = r_pflag;
  assign map_data_flag      = r_mflag;

endmodule

// File: tb/tb_serial_msg_rx.sv
module tb_serial_msg_rx;

  import serial_msg_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_data_ready = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic [7:0] msg_out;
  logic       particle_data_flag;
  logic       map_data_flag;

  always #5 clk = ~clk;

  serial_msg_rx #(
    .HEADER_LENGHT       (5),
    .DATA_MESSAGE_LENGHT (16),
    .MAP_DATA_LENGHT     (16)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .rx_data_ready      (rx_data_ready),
    .rx_data            (rx_data),
    .msg_out            (msg_out),
    .particle_data_flag (particle_data_flag),
    .map_data_flag      (map_data_flag)
  );

  typedef struct packed {
    logic       is_map;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  logic [7:0] p_hdr [5] = '{8'd70, 8'd71, 8'd72, 8'd73, 8'd74};
  logic [7:0] m_hdr [5] = '{8'd77, 8'd65, 8'd80, 8'd73, 8'd74};

  // Scoreboard monitor: every strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (particle_data_flag || map_data_flag) begin
      pulses++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: got p=%b m=%b msg_out=%0d, required no pulse",
                 particle_data_flag, map_data_flag, msg_out);
      end else begin
        mon_e = sb.pop_front();
        if ({particle_data_flag, map_data_flag} !== (mon_e.is_map ? 2'b01 : 2'b10)) begin
          failures++;
          $display("FAIL pulse_type: got p=%b m=%b, required is_map=%b",
                   particle_data_flag, map_data_flag, mon_e.is_map);
        end
        checks++;
        if (msg_out !== mon_e.data) begin
          failures++;
          $display("FAIL pulse_data: got %0d, required %0d", msg_out, mon_e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk);
    #1;
    rx_data       = b;
    rx_data_ready = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic is_map, input logic [7:0] base, input int n);
    for (int i = 0; i < 5; i++)
      send_byte(is_map ? m_hdr[i] : p_hdr[i], 2);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{is_map: is_map, data: base + 8'(i)});
      send_byte(base + 8'(i), 2);
    end
  endtask

  task automatic end_scenario(input string name, input int exp_pulses);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_leftover: got %0d pending bytes, required 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (pulses != exp_pulses) begin
      failures++;
      $display("FAIL %s_pulses: got %0d, required %0d", name, pulses, exp_pulses);
    end
    checks++;
    if (dut.r_state !== HUNT) begin
      failures++;
      $display("FAIL %s_state: got %0d, required HUNT", name, dut.r_state);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #100;
    checks++;
    if (msg_out !== 8'd0) begin
      failures++;
      $display("FAIL reset_msg_out: got %0d, required 0", msg_out);
    end
    checks++;
    if ({particle_data_flag, map_data_flag} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: got %b, required 00", {particle_data_flag, map_data_flag});
    end
  endtask

  task automatic test_particle_frame();
    pulses = 0;
    send_frame(1'b0, 8'd1, 16);
    end_scenario("particle", 16);
    checks++;
    if (msg_out !== 8'd16) begin
      failures++;
      $display("FAIL particle_hold: got %0d, required 16", msg_out);
    end
  endtask

  task automatic test_back_to_back();
    pulses = 0;
    #100;
    send_frame(1'b0, 8'd1, 16);
    end_scenario("repeat", 16);
  endtask

  task automatic test_false_header();
    pulses = 0;
    send_byte(8'd71, 7);
    send_byte(8'd72, 2);
    send_byte(8'd73, 2);
    send_byte(8'd74, 2);
    for (int i = 1; i <= 16; i++)
      send_byte(8'(i), 2);
    end_scenario("false_hdr", 0);
  endtask

  task automatic test_map_frame();
    pulses = 0;
    send_frame(1'b1, 8'hA0, 16);
    end_scenario("map", 16);
  endtask

  task automatic test_reset_mid_message();
    pulses = 0;
    send_byte(8'd70, 2);
    send_byte(8'd71, 2);
    send_byte(8'd72, 2);
    do_reset();
    #1;
    checks++;
    if (msg_out !== 8'd0) begin
      failures++;
      $display("FAIL midreset_msg_out: got %0d, required 0", msg_out);
    end
    send_frame(1'b0, 8'd1, 16);
    end_scenario("midreset", 16);
  endtask

`ifdef SERIAL_MSG_TIMEOUT_EN
  task automatic test_timeout();
    pulses = 0;
    send_frame(1'b0, 8'd1, 3);
    repeat (1100) @(posedge clk);
    #1;
    checks++;
    if (dut.r_state !== HUNT) begin
      failures++;
      $display("FAIL timeout_state: got %0d, required HUNT", dut.r_state);
    end
    send_frame(1'b0, 8'd1, 16);
    end_scenario("timeout", 19);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_particle_frame();
    test_back_to_back();
    test_false_header();
    test_map_frame();
    test_reset_mid_message();
`ifdef SERIAL_MSG_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
